// File: rtl/mips_mem_responder.sv
// mips_mem_responder
//   Memory and MMIO responder for a single-cycle MIPS core. It provides:
//     - a unified word RAM with two combinational read ports (fetch and data)
//       and one synchronous write port, shared between preload and the core;
//     - a preload phase (LOAD) that holds the core in reset until the image
//       has been streamed in;
//     - MMIO: a byte TX channel (valid/ready), a status register, and an
//       optional free-running timer with a compare interrupt.
//   Optional feature macro: MIPS_MEM_TIMER_EN (COUNT/COMPARE/irq). When the
//   macro is undefined, COUNT and COMPARE read 0, writes to them are dropped
//   and irq is tied low.
//
// Ports
//   clk, reset_n         clock; synchronous active-low reset
//   cpu_reset            core reset, high while in LOAD
//   pc / instr           fetch port (combinational)
//   memwrite, memaddr,
//   memwritedata,
//   memreaddata          data port (combinational read, write on the edge)
//   load_valid/ready,
//   load_addr/data/last  preload stream
//   tx_valid/ready/data  byte TX channel
//   irq                  sticky timer-match interrupt
module mips_mem_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          cpu_reset,
  input  logic [31:0]   pc,
  output logic [31:0]   instr,
  input  logic          memwrite,
  input  logic [31:0]   memaddr,
  input  logic [31:0]   memwritedata,
  output logic [31:0]   memreaddata,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [7:0]    tx_data,
  output logic          irq
);

  localparam logic [31:0] A_COUNT   = 32'hFFFF_0000;
  localparam logic [31:0] A_TXDATA  = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS  = 32'hFFFF_0008;
  localparam logic [31:0] A_COMPARE = 32'hFFFF_000C;

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_LOAD;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_LOAD && load_valid && load_last) state_nxt = S_RUN;
  end

  wire run = (state == S_RUN);
  assign cpu_reset  = ~run;
  assign load_ready = ~run;

  // ---------------------------------------------------------------- decode
  // RAM occupies byte addresses 0 .. DEPTH*4-1: every bit above the word
  // index must be zero, otherwise the access would alias into the array.
  wire pc_in_ram  = (pc[31:AW+2] == '0);
  wire da_in_ram  = (memaddr[31:AW+2] == '0);
  wire core_wr    = run & memwrite;
  wire wr_txdata  = core_wr & (memaddr == A_TXDATA);
  wire wr_status  = core_wr & (memaddr == A_STATUS);
  wire wr_compare = core_wr & (memaddr == A_COMPARE);

  // ---------------------------------------------------------------- RAM
  logic [31:0] mem [DEPTH];

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;

  // One write port: the preload stream owns it in LOAD, the core in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = memaddr[AW+1:2];
    ram_wdata = memwritedata;
    if (reset_n) begin
      if (!run) begin
        ram_we    = load_valid;
        ram_waddr = load_addr;
        ram_wdata = load_data;
      end else begin
        ram_we    = memwrite & da_in_ram;
      end
    end
  end

  // Contents are deliberately not cleared by reset so an image survives it.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  // ---------------------------------------------------------------- TX
  logic overflow;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      // A write on the handshake edge still sees tx_valid=1 and is dropped.
      if (wr_txdata) begin
        if (tx_valid) begin
          overflow <= 1'b1;
        end else begin
          tx_valid <= 1'b1;
          tx_data  <= memwritedata[7:0];
        end
      end
      if (wr_status) overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- timer
  logic [31:0] count_rd;
  logic [31:0] compare_rd;

`ifdef MIPS_MEM_TIMER_EN
  logic [31:0] counter;
  logic [31:0] compare;
  logic        irq_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      counter <= 32'h0;
      compare <= 32'hFFFF_FFFF;
      irq_q   <= 1'b0;
    end else begin
      if (run) counter <= counter + 32'd1;
      // A COMPARE write wins over a match on the same edge.
      if (wr_compare) begin
        compare <= memwritedata;
        irq_q   <= 1'b0;
      end else if (counter == compare) begin
        irq_q   <= 1'b1;
      end
    end
  end

  assign count_rd   = counter;
  assign compare_rd = compare;
  assign irq        = irq_q;
`else
  assign count_rd   = 32'h0;
  assign compare_rd = 32'h0;
  assign irq        = 1'b0;
  logic  unused_wr_compare;
  assign unused_wr_compare = wr_compare;
`endif

  // ---------------------------------------------------------------- reads
  always_comb begin
    instr = 32'h0;
    if (run && pc_in_ram) instr = mem[pc[AW+1:2]];
  end

  always_comb begin
    memreaddata = 32'h0;
    if (run) begin
      if (da_in_ram) begin
        memreaddata = mem[memaddr[AW+1:2]];
      end else begin
        case (memaddr)
          A_COUNT:   memreaddata = count_rd;
          A_TXDATA:  memreaddata = {24'h0, tx_data};
          A_STATUS:  memreaddata = {30'h0, overflow, tx_valid};
          A_COMPARE: memreaddata = compare_rd;
          default:   memreaddata = 32'h0;
        endcase
      end
    end
  end

  // Byte offset within a fetched word carries no information.
  logic  unused_pc_lsb;
  assign unused_pc_lsb = &{1'b0, pc[1:0]};

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Responder for the single-cycle MIPS core's instruction-fetch port (pc to instr) and data port (memwrite, memaddr, memwritedata to memreaddata).
- Unified word RAM with two combinational read ports and one synchronous write port.
- Small MMIO block: byte TX channel with valid/ready handshake, status register, optional timer.
- Includes a program-preload phase that holds the core in reset until the image is loaded.

Parameters:
- DEPTH, 1024: RAM depth in 32-bit words; power of two.
- AW, 10: word-address width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cpu_reset  out  1  drives the core's reset; high during LOAD.
- pc  in  32  core fetch address.
- instr  out  32  fetched instruction.
- memwrite  in  1  core store strobe.
- memaddr  in  32  core data byte address.
- memwritedata  in  32  store data.
- memreaddata  out  32  load data.
- load_valid  in  1  preload beat valid.
- load_ready  out  1  preload beat accepted.
- load_addr  in  AW  preload word address.
- load_data  in  32  preload word.
- load_last  in  1  final preload beat.
- tx_valid  out  1  TX byte valid.
- tx_ready  in  1  TX sink ready.
- tx_data  out  8  TX byte.
- irq  out  1  timer match; tied 0 when the timer is compiled out.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=LOAD, cpu_reset=1, load_ready=1.
  - tx_valid=0, tx_data=0, overflow=0.
  - counter=0, compare=0xFFFFFFFF, irq=0.
  - RAM contents are not cleared.
  - Reset asserted mid-handshake aborts it; tx_valid drops the next cycle.
- State machine has two states, LOAD and RUN.
- LOAD:
  - Each cycle with load_valid=1 writes load_data to RAM[load_addr].
  - A beat with load_last=1 moves the state to RUN on that edge.
  - In RUN: cpu_reset=0 and load_ready=0 from the next cycle; load inputs are ignored.
  - While in LOAD: core writes are ignored, instr=0, memreaddata=0.
- RAM region, byte addresses 0 .. DEPTH*4-1:
  - Word index is addr[AW+1:2]; addr[1:0] is ignored.
  - Reads are combinational: instr=RAM[pc], memreaddata=RAM[memaddr].
  - Writes happen at the edge when memwrite=1.
  - A read of a word being written in the same cycle returns the old value; the new value is visible next cycle.
- Address decode outside the RAM:
  - Any address outside RAM and MMIO reads 0; writes to it are dropped.
  - instr for an out-of-range pc is 0 (executes as a NOP).
- MMIO map (full 32-bit compare):
  - 0xFFFF0000 COUNT: read-only.
  - 0xFFFF0004 TXDATA: write sends a byte; read returns {24'b0, tx_data}.
  - 0xFFFF0008 STATUS: bit0=tx_valid (busy), bit1=overflow; any write clears overflow.
  - 0xFFFF000C COMPARE: read/write.
- TX handshake:
  - A write to TXDATA with tx_valid=0 latches memwritedata[7:0] into tx_data; tx_valid=1 from the next cycle.
  - tx_valid and tx_data hold stable until a cycle with tx_valid & tx_ready; tx_valid=0 after that edge.
  - A write to TXDATA while tx_valid=1 is dropped and sets overflow.
  - A write landing on the same edge as the handshake counts as busy and is also dropped.
- Latency:
  - Reads: 0 cycles.
  - Writes and MMIO side effects: visible 1 cycle after the edge.

Optional Feature:
- Macro: MIPS_MEM_TIMER_EN.
- Defined:
  - COUNT increments by 1 every cycle in RUN, wrapping 0xFFFFFFFF to 0; it holds at 0 in LOAD.
  - When COUNT==COMPARE at an edge, irq=1 from the next cycle. irq is sticky.
  - A write to COMPARE loads the new value and clears irq on that edge; a match on the same edge is lost.
- Undefined:
  - COUNT and COMPARE read 0; writes to them are dropped.
  - irq is constant 0; no counter flops are synthesised.

Test Plan:
- Preload: reset_n low 2 cycles, then load words 0x20080005 at addr 0 and 0x00000000 at addr 1, with load_last on the 2nd beat -> cpu_reset falls the cycle after; pc=0 gives instr=0x20080005.
- Store/load: in RUN, memwrite=1, memaddr=0x10, data=0xDEADBEEF -> memreaddata=0xDEADBEEF from the next cycle; a same-cycle read returns the old value.
- TX backpressure: write 0x41 to 0xFFFF0004 with tx_ready=0 for 3 cycles -> tx_valid=1 with tx_data=0x41 stable; tx_ready=1 -> tx_valid=0 the following cycle.
- TX overflow: write 0x42 while busy -> tx_data stays 0x41 and STATUS reads 0x3; write STATUS -> reads 0x1.
- Out of range: read 0x00100000 -> 0; write to it does not alter RAM[0]; pc=0x00100000 -> instr=0.
- Timer (MIPS_MEM_TIMER_EN): COMPARE=20 after entering RUN -> irq rises one cycle after COUNT==20 and stays high; rewrite COMPARE -> irq=0. With the macro undefined: COUNT reads 0 and irq stays 0.
